// File: rtl/bsg_mem_1r1w_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bsg_mem_1r1w_stream_reader_if
// Bundles the signals of the stream reader: the command handshake, the
// asynchronous memory read port and the valid/yumi output stream.
//   cmd_v_i / cmd_addr_i / cmd_len_i / cmd_ready_o : command handshake
//   mem_r_v_o / mem_r_addr_o / mem_r_data_i        : memory read port
//   v_o / data_o / yumi_i                          : output word stream
//   done_o                                         : command-complete pulse
// Modport slave is the reader's view; master is the view of its environment.
// ---------------------------------------------------------------------------
interface bsg_mem_1r1w_stream_reader_if
  #(parameter int width_p = 32
   ,parameter int els_p   = 16
   );

   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int len_width_lp  = $clog2(els_p + 1);

   logic                     cmd_v_i;
   logic [addr_width_lp-1:0] cmd_addr_i;
   logic [len_width_lp-1:0]  cmd_len_i;
   logic                     cmd_ready_o;
   logic                     mem_r_v_o;
   logic [addr_width_lp-1:0] mem_r_addr_o;
   logic [width_p-1:0]       mem_r_data_i;
   logic                     v_o;
   logic [width_p-1:0]       data_o;
   logic                     yumi_i;
   logic                     done_o;

   modport slave
     (input  cmd_v_i, cmd_addr_i, cmd_len_i, mem_r_data_i, yumi_i
     ,output cmd_ready_o, mem_r_v_o, mem_r_addr_o, v_o, data_o, done_o
     );

   modport master
     (output cmd_v_i, cmd_addr_i, cmd_len_i, mem_r_data_i, yumi_i
     ,input  cmd_ready_o, mem_r_v_o, mem_r_addr_o, v_o, data_o, done_o
     );

endinterface

// File: rtl/bsg_mem_1r1w_stream_reader.sv
// ---------------------------------------------------------------------------
// bsg_mem_1r1w_stream_reader
// Read-side engine for a 1r1w memory with asynchronous read. A command gives
// a start address and a word count; the block then reads one address per
// cycle (wrapping modulo els_p) and streams the words through a single-entry
// registered valid/yumi output. done_o pulses for one cycle once the last
// word has been taken.
// Ports:
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : bsg_mem_1r1w_stream_reader_if.slave (command, memory read
//             port, output stream, done pulse)
// ---------------------------------------------------------------------------
module bsg_mem_1r1w_stream_reader
  #(parameter int width_p = 32
   ,parameter int els_p   = 16
   )
   (input  logic clk_i
   ,input  logic reset_i
   ,bsg_mem_1r1w_stream_reader_if.slave bus
   );

   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int len_width_lp  = $clog2(els_p + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                   r_state;
   logic [addr_width_lp-1:0] r_addr;
   logic [len_width_lp-1:0]  r_remaining;
   logic [width_p-1:0]       r_data;
   logic                     r_v;
   logic                     r_done;
   logic                     r_ready;

   logic                     w_free;
   logic                     w_capture;
   logic                     w_exit;
   logic [addr_width_lp-1:0] w_addr_next;

   // Output slot is free when empty or being drained; capture and exit decode.
   always_comb begin
      w_free      = ~r_v | bus.yumi_i;
      w_capture   = 1'b0;
      w_exit      = 1'b0;
      w_addr_next = r_addr;
      if (r_state == S_STREAM) begin
         w_capture = (r_remaining != {len_width_lp{1'b0}}) & w_free;
         w_exit    = (r_remaining == {len_width_lp{1'b0}}) & w_free;
      end else begin
         w_capture = 1'b0;
         w_exit    = 1'b0;
      end
      // Wrap to 0 after the last entry; for els_p=1 this keeps the address at 0.
      if (r_addr == addr_width_lp'(els_p - 1)) begin
         w_addr_next = {addr_width_lp{1'b0}};
      end else begin
         w_addr_next = r_addr + addr_width_lp'(1);
      end
   end

   // Control FSM plus the output register; ready/done are registered alongside.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_addr      <= {addr_width_lp{1'b0}};
         r_remaining <= {len_width_lp{1'b0}};
         r_data      <= {width_p{1'b0}};
         r_v         <= 1'b0;
         r_done      <= 1'b0;
         r_ready     <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_v_i) begin
                  r_ready <= 1'b0;
                  if (bus.cmd_len_i == {len_width_lp{1'b0}}) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_addr      <= bus.cmd_addr_i;
                     r_remaining <= bus.cmd_len_i;
                     r_state     <= S_STREAM;
                  end
               end
            end
            S_STREAM: begin
               if (w_capture) begin
                  r_data      <= bus.mem_r_data_i;
                  r_v         <= 1'b1;
                  r_addr      <= w_addr_next;
                  r_remaining <= r_remaining - len_width_lp'(1);
               end else if (bus.yumi_i) begin
                  r_v <= 1'b0;
               end
               // Leaves in the cycle of the final yumi (or immediately if already empty).
               if (w_exit) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_v     <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cmd_ready_o  = r_ready;
   assign bus.done_o       = r_done;
   assign bus.v_o          = r_v;
   assign bus.data_o       = r_data;
   assign bus.mem_r_addr_o = r_addr;
   // The read strobe must coincide with the capture because the memory reads asynchronously.
   assign bus.mem_r_v_o    = w_capture;

   bsg_mem_1r1w_stream_reader_chk
     #(.els_p(els_p), .addr_width_p(addr_width_lp), .len_width_p(len_width_lp))
   chk
     (.clk_i      (clk_i)
     ,.reset_i    (reset_i)
     ,.cmd_v_i    (bus.cmd_v_i)
     ,.cmd_ready_i(r_ready)
     ,.cmd_addr_i (bus.cmd_addr_i)
     ,.cmd_len_i  (bus.cmd_len_i)
     ,.yumi_i     (bus.yumi_i)
     ,.v_i        (r_v)
     );

endmodule

// ---------------------------------------------------------------------------
// bsg_mem_1r1w_stream_reader_chk
// Protocol checks on the reader's inputs: yumi only while a word is valid,
// and accepted commands must stay inside the memory.
// ---------------------------------------------------------------------------
module bsg_mem_1r1w_stream_reader_chk
  #(parameter int els_p        = 16
   ,parameter int addr_width_p = 4
   ,parameter int len_width_p  = 5
   )
   (input logic                    clk_i
   ,input logic                    reset_i
   ,input logic                    cmd_v_i
   ,input logic                    cmd_ready_i
   ,input logic [addr_width_p-1:0] cmd_addr_i
   ,input logic [len_width_p-1:0]  cmd_len_i
   ,input logic                    yumi_i
   ,input logic                    v_i
   );

   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      yumi_i |-> v_i);

   a_cmd_addr_range: assert property (@(posedge clk_i) disable iff (reset_i)
      (cmd_v_i & cmd_ready_i) |-> (int'(cmd_addr_i) < els_p));

   a_cmd_len_range: assert property (@(posedge clk_i) disable iff (reset_i)
      (cmd_v_i & cmd_ready_i) |-> (int'(cmd_len_i) <= els_p));

endmodule

// File: tb/tb_bsg_mem_1r1w_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bsg_mem_1r1w_stream_reader
// Stimulus pushes expected words/addresses into queues; a monitor compares
// whenever the reader presents a word, a read strobe or a done pulse.
// ---------------------------------------------------------------------------
module tb_bsg_mem_1r1w_stream_reader;

   localparam int W = 32;
   localparam int E = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bsg_mem_1r1w_stream_reader_if #(.width_p(W), .els_p(E)) bus();

   bsg_mem_1r1w_stream_reader #(.width_p(W), .els_p(E)) dut
     (.clk_i(clk), .reset_i(reset), .bus(bus));

   logic [31:0] mem [E];
   assign bus.mem_r_data_i = mem[bus.mem_r_addr_o];

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   int addr_q[$];
   int cyc = 0;
   int rd_cnt = 0, v_cnt = 0, done_cnt = 0, pop_cnt = 0;
   int last_yumi_cyc = 0, done_cyc = 0;
   bit chk_done_lat = 1'b0;
   bit pat_mode = 1'b0;
   logic [5:0] pat = 6'b110100;   // yumi pattern 0,0,1,0,1,1 (bit 0 first)

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Consumer: takes every valid word, or follows the stall pattern once v_o rises.
   initial begin
      int idx;
      bit started;
      idx = 0;
      started = 1'b0;
      bus.yumi_i = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus.yumi_i = 1'b0;
            idx = 0;
            started = 1'b0;
         end else if (pat_mode) begin
            if (bus.v_o) started = 1'b1;
            if (started && idx < 6) begin
               bus.yumi_i = bus.v_o & pat[idx];
               idx++;
            end else begin
               bus.yumi_i = bus.v_o;
            end
         end else begin
            bus.yumi_i = bus.v_o;
            idx = 0;
            started = 1'b0;
         end
      end
   end

   // Monitor: scoreboard comparisons on words, read addresses and done timing.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            if (bus.v_o) begin
               v_cnt++;
               if (exp_q.size() == 0) fail_now("unexpected_v_o");
               else begin
                  chk("data_o", bus.data_o, exp_q[0]);
                  if (bus.yumi_i) begin
                     void'(exp_q.pop_front());
                     pop_cnt++;
                     last_yumi_cyc = cyc;
                  end
               end
            end
            if (bus.mem_r_v_o) begin
               rd_cnt++;
               if (addr_q.size() == 0) fail_now("unexpected_mem_r_v_o");
               else chk("mem_r_addr_o", bus.mem_r_addr_o, addr_q.pop_front());
            end
            if (bus.done_o) begin
               done_cnt++;
               done_cyc = cyc;
               if (chk_done_lat) chk("done_latency", cyc, last_yumi_cyc + 1);
            end
         end
      end
   end

   task automatic push_exp(input int a, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(32'h100 + ((a + i) % E));
         addr_q.push_back((a + i) % E);
      end
   endtask

   task automatic send(input int a, input int n);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      bus.cmd_v_i    = 1'b1;
      bus.cmd_addr_i = 4'(a);
      bus.cmd_len_i  = 5'(n);
      for (int t = 0; t < 100; t++) begin
         @(negedge clk); #2;
         if (bus.cmd_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("cmd_accept_timeout");
      @(posedge clk); #1;
      bus.cmd_v_i = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk); #2;
         if (bus.done_o) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("done_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_cyc, base, dsnap;
      bit ok;
      for (int i = 0; i < E; i++) mem[i] = 32'h100 + i;
      bus.cmd_v_i = 1'b0;
      bus.cmd_addr_i = 4'd0;
      bus.cmd_len_i = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_v_o", bus.v_o, 1'b0);
      chk("rst_done_o", bus.done_o, 1'b0);
      chk("rst_mem_r_v_o", bus.mem_r_v_o, 1'b0);
      chk("rst_data_o", bus.data_o, 32'h0);
      chk("rst_mem_r_addr_o", bus.mem_r_addr_o, 4'd0);
      chk("rst_cmd_ready_o", bus.cmd_ready_o, 1'b1);
      @(negedge clk);
      reset = 1'b0;

      // Basic: addr 2, len 4, yumi always
      rd_cnt = 0; v_cnt = 0; chk_done_lat = 1'b1;
      exp_q = '{32'h102, 32'h103, 32'h104, 32'h105};
      addr_q = '{2, 3, 4, 5};
      send(2, 4);
      wait_done();
      chk("basic_rd_cnt", rd_cnt, 4);
      chk("basic_v_cycles", v_cnt, 4);
      @(negedge clk); #2;
      chk("done_one_cycle", bus.done_o, 1'b0);
      chk("ready_after_done", bus.cmd_ready_o, 1'b1);

      // Wrap: addr 14, len 4
      rd_cnt = 0;
      exp_q = '{32'h10E, 32'h10F, 32'h100, 32'h101};
      addr_q = '{14, 15, 0, 1};
      send(14, 4);
      wait_done();
      chk("wrap_rd_cnt", rd_cnt, 4);
      chk("wrap_drained", exp_q.size(), 0);

      // Backpressure: addr 0, len 3, yumi 0,0,1,0,1,1
      rd_cnt = 0; v_cnt = 0; pat_mode = 1'b1;
      exp_q = '{32'h100, 32'h101, 32'h102};
      addr_q = '{0, 1, 2};
      send(0, 3);
      wait_done();
      chk("bp_rd_cnt", rd_cnt, 3);
      chk("bp_v_cycles", v_cnt, 6);
      chk("bp_drained", exp_q.size(), 0);
      pat_mode = 1'b0;

      // Zero length
      rd_cnt = 0; v_cnt = 0; done_cnt = 0; chk_done_lat = 1'b0;
      send(0, 0);
      chk("zero_ready_low", bus.cmd_ready_o, 1'b0);
      chk("zero_done_high", bus.done_o, 1'b1);
      @(posedge clk); #1;
      chk("zero_ready_back", bus.cmd_ready_o, 1'b1);
      chk("zero_done_low", bus.done_o, 1'b0);
      chk("zero_done_cnt", done_cnt, 1);
      chk("zero_v_cnt", v_cnt, 0);
      chk("zero_rd_cnt", rd_cnt, 0);

      // Full buffer then a back-to-back command held valid
      rd_cnt = 0; chk_done_lat = 1'b1;
      push_exp(5, 16);
      push_exp(0, 1);
      send(5, 16);
      bus.cmd_v_i = 1'b1;
      bus.cmd_addr_i = 4'd0;
      bus.cmd_len_i = 5'd1;
      ok = 1'b0;
      acc_cyc = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk); #2;
         if (bus.cmd_ready_o) begin ok = 1'b1; acc_cyc = cyc; break; end
      end
      if (!ok) fail_now("b2b_accept_timeout");
      else chk("b2b_accept_cycle", acc_cyc, done_cyc + 1);
      @(posedge clk); #1;
      bus.cmd_v_i = 1'b0;
      wait_done();
      chk("full_rd_cnt", rd_cnt, 17);
      chk("full_drained", exp_q.size(), 0);

      // Async reset after the 2nd of 8 words
      push_exp(0, 8);
      base = pop_cnt;
      send(0, 8);
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (pop_cnt >= base + 2) begin ok = 1'b1; break; end
         @(negedge clk); #2;
      end
      if (!ok) fail_now("reset_wait_timeout");
      dsnap = done_cnt;
      reset = 1'b1;
      exp_q.delete();
      addr_q.delete();
      #1;
      chk("mid_rst_v_o", bus.v_o, 1'b0);
      chk("mid_rst_done_o", bus.done_o, 1'b0);
      chk("mid_rst_mem_r_v_o", bus.mem_r_v_o, 1'b0);
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("post_rst_ready", bus.cmd_ready_o, 1'b1);
      chk("post_rst_no_done", done_cnt, dsnap);
      exp_q = '{32'h103, 32'h104};
      addr_q = '{3, 4};
      send(3, 2);
      wait_done();
      chk("post_rst_drained", exp_q.size(), 0);
      chk("post_rst_done_cnt", done_cnt, dsnap + 1);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
